// File: rtl/ssd_driver.sv
// Four-digit seven-segment driver: sequential double-dabble converts a 13-bit
// binary value to BCD, then a multiplexed scan shows it with leading-zero blanking.
module ssd_driver #(
  parameter int REFRESH_CNT    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value_i,
  output logic [15:0] bcd_o,
  output logic        busy_o,
  output logic [3:0]  anode_o,
  output logic [6:0]  seg_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CNT - 1);
  localparam logic [6:0] ZERO_CODE = SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;

  state_t      state, state_next;
  logic        pending, pending_next;
  logic [12:0] last_val, last_val_next;
  logic [12:0] bin_sr, bin_sr_next;
  logic [15:0] bcd_acc, bcd_acc_next, adj;
  logic [15:0] bcd_next;
  logic [3:0]  shift_cnt, shift_cnt_next;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    anode_next;
  logic [6:0]    seg_hi, seg_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd_acc[4*i +: 4] >= 4'd5) ? bcd_acc[4*i +: 4] + 4'd3
                                                   : bcd_acc[4*i +: 4];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    pending_next   = pending;
    last_val_next  = last_val;
    bin_sr_next    = bin_sr;
    bcd_acc_next   = bcd_acc;
    shift_cnt_next = shift_cnt;
    bcd_next       = bcd_o;
    case (state)
      IDLE: begin
        if (pending || (value_i != last_val)) begin
          last_val_next  = value_i;
          bin_sr_next    = value_i;
          bcd_acc_next   = '0;
          shift_cnt_next = '0;
          pending_next   = 1'b0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        bcd_acc_next   = {adj[14:0], bin_sr[12]};
        bin_sr_next    = {bin_sr[11:0], 1'b0};
        shift_cnt_next = shift_cnt + 4'd1;
        if (shift_cnt == 4'd12) state_next = DONE;
      end
      DONE: begin
        bcd_next   = bcd_acc;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b1;
      last_val  <= '0;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      shift_cnt <= '0;
      bcd_o     <= '0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      last_val  <= last_val_next;
      bin_sr    <= bin_sr_next;
      bcd_acc   <= bcd_acc_next;
      shift_cnt <= shift_cnt_next;
      bcd_o     <= bcd_next;
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A digit is blank when it and everything above it in bcd_o is zero.
  always_comb begin
    digit = bcd_o[{digit_idx, 2'b00} +: 4];
    case (digit_idx)
      2'd1:    blank = (bcd_o[15:4] == '0);
      2'd2:    blank = (bcd_o[15:8] == '0);
      2'd3:    blank = (bcd_o[15:12] == '0);
      default: blank = 1'b0;
    endcase
    anode_next = blank ? 4'b1111 : ~(4'b0001 << digit_idx);
    seg_hi     = blank ? 7'h00 : seg_code(digit);
    seg_next   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_o <= 4'b1110;
      seg_o   <= ZERO_CODE;
    end else begin
      anode_o <= anode_next;
      seg_o   <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_driver.sv
// Randomized bench for ssd_driver: an integer-level timing/decimal model is compared
// every cycle, plus literal checks of conversion latency, scan patterns and reset abort.
module tb_ssd_driver;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value_i;
  logic [15:0] bcd_o;
  logic        busy_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;

  ssd_driver #(.REFRESH_CNT(RC), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .bcd_o(bcd_o),
    .busy_o(busy_o), .anode_o(anode_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_hi(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  // Model: conversions take 14 edges from capture; the display shows the decimal
  // digits of the last finished value, one slot per RC cycles, one cycle late.
  int p10[4] = '{1, 10, 100, 1000};
  bit   m_valid = 0;
  bit   m_active, m_pending, m_lit;
  int   m_left, m_conv, m_last, m_num, m_cyc;
  logic [3:0] m_anode;
  logic [6:0] m_seg;

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      m_valid = 1; m_active = 0; m_pending = 1; m_num = 0; m_cyc = 0;
      m_anode = 4'b1110; m_seg = 7'b1000000; m_lit = 1;
    end else if (m_valid) begin
      idx     = (m_cyc / RC) % 4;
      m_lit   = (idx == 0) || (m_num >= p10[idx]);
      m_anode = m_lit ? 4'((~(1 << idx)) & 15) : 4'b1111;
      m_seg   = ~seg_hi((m_num / p10[idx]) % 10);
      m_cyc++;
      if (!m_active) begin
        if (m_pending || int'(value_i) != m_last) begin
          m_active = 1; m_left = 14; m_conv = int'(value_i);
          m_last = m_conv; m_pending = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_active = 0;
          m_num = m_conv;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy_o), 32'(m_active));
      check("bcd", 32'(bcd_o), 32'(to_bcd(m_num)));
      check("anode", 32'(anode_o), 32'(m_anode));
      if (m_lit) check("seg", 32'(seg_o), 32'(m_seg));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // Applies v at a negedge and counts edges until bcd_o shows exp.
  task automatic run_value(input logic [12:0] v, input logic [15:0] exp,
                           input int exp_edges, input string name);
    int n = 0;
    bit found = 0;
    value_i = v;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (bcd_o == exp) found = 1;
    end
    check(name, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    int n;
    int hi_cnt;
    logic [3:0] seen;
    rst = 1'b1;
    value_i = '0;
    repeat (2) @(negedge clk);
    check("rst_anode", 32'(anode_o), 32'b1110);
    check("rst_seg", 32'(seg_o), 32'b1000000);
    rst = 1'b0;

    // Conversion of 0 triggered by the reset-set pending flag.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_o) n++;
      else if (n > 0) break;
    end
    check("busy_len_after_reset", 32'(n), 32'd14);
    check("bcd_zero", 32'(bcd_o), 32'h0000);
    repeat (20) @(negedge clk);

    // 1234: latency and scan patterns.
    wait_idle();
    run_value(13'd1234, 16'h1234, 15, "lat_1234");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (anode_o)
        4'b1110: check("scan_d0", 32'(seg_o), 32'b0011001);
        4'b1101: check("scan_d1", 32'(seg_o), 32'b0110000);
        4'b1011: check("scan_d2", 32'(seg_o), 32'b0100100);
        4'b0111: check("scan_d3", 32'(seg_o), 32'b1111001);
        default: check("scan_anode", 32'(anode_o), 32'b1110);
      endcase
    end

    // 8191: all digits lit.
    wait_idle();
    run_value(13'd8191, 16'h8191, 15, "lat_8191");
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (anode_o[d] == 1'b0) seen[d] = 1'b1;
    end
    check("all_lit_8191", 32'(seen), 32'hF);

    // 100 then 57 mid-conversion.
    wait_idle();
    value_i = 13'd100;
    repeat (4) @(negedge clk);
    run_value(13'd57, 16'h0100, 11, "mid_change_100");
    run_value(13'd57, 16'h0057, 15, "second_conv_57");
    hi_cnt = 0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (anode_o == 4'b1011 || anode_o == 4'b0111) hi_cnt++;
      if (anode_o == 4'b1111) seen[0] = 1'b1;
    end
    check("blank_hi_57", 32'(hi_cnt), 32'd0);
    check("blank_seen_57", 32'(seen[0]), 32'd1);

    // Reset during SHIFT aborts, then 999 reconverts.
    wait_idle();
    value_i = 13'd999;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_bcd", 32'(bcd_o), 32'h0000);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_anode", 32'(anode_o), 32'b1110);
    check("abort_seg", 32'(seg_o), 32'b1000000);
    rst = 1'b0;
    run_value(13'd999, 16'h0999, 15, "after_rst_999");

    // Random values, hold times and occasional resets.
    for (int i = 0; i < 60; i++) begin
      value_i = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_driver.md
SSD_DRIVER -- requirements
Module: ssd_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_CNT, default 100000, giving the clock cycles each digit is lit (minimum 2).
REQ-002 The block SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1, seg_o is the bitwise inverse of the active-high pattern.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port value_i, input, 13 bits: unsigned binary value to display, range 0..8191, driven by the CPU ssd_o output.
REQ-006 Port bcd_o, output, 16 bits: registered BCD of the last converted value; digit 0 is in bits [3:0].
REQ-007 Port busy_o, output, 1 bit: high while a conversion is in progress.
REQ-008 Port anode_o, output, 4 bits: digit enables, active low; bit n enables digit n.
REQ-009 Port seg_o, output, 7 bits: segment pattern ordered {g,f,e,d,c,b,a}.

Function
REQ-010 The converter SHALL be an FSM with states IDLE, SHIFT and DONE, using sequential double-dabble.
REQ-011 In IDLE, the FSM SHALL start a conversion when value_i differs from the last captured value, or when the pending flag (set by reset) is high.
- On start it captures value_i into the shift register, clears the 16-bit BCD accumulator and the shift counter, clears pending, and goes to SHIFT.
REQ-012 Each SHIFT cycle SHALL first add 3 to every BCD nibble that is 5 or more, then shift {BCD, binary} left by one bit.
REQ-013 After exactly 13 SHIFT cycles the FSM SHALL go to DONE.
REQ-014 In DONE, the FSM SHALL load the accumulator into bcd_o and return to IDLE.
- Timing: with capture on edge T, bcd_o is valid from edge T+14.
- A back-to-back restart from IDLE is allowed on the cycle after DONE.
REQ-015 busy_o SHALL be high in SHIFT and DONE and low in IDLE.
REQ-016 Changes on value_i during SHIFT or DONE SHALL be ignored; they are re-evaluated in IDLE, so the final bcd_o always matches the last stable value_i.
REQ-017 The thousands digit SHALL never exceed 8; the other digits SHALL never exceed 9.
REQ-018 The refresh counter SHALL count 0..REFRESH_CNT-1 and then wrap to 0.
- On each wrap, the 2-bit digit index increments modulo 4 (3 -> 0).
REQ-019 anode_o and seg_o SHALL be registered from the digit index and bcd_o, one cycle behind the index.
REQ-020 Active-high segment codes for digits 0-9 SHALL be 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
REQ-021 Leading-zero blanking: a digit n > 0 SHALL be blanked when it and all higher digits of bcd_o are 0.
- A blanked digit drives anode_o = 4'b1111.
- Digit 0 is never blanked.
REQ-022 While a digit is displayed, anode_o SHALL have exactly one bit low: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-023 The display SHALL keep showing the old bcd_o during a conversion, with no flicker to intermediate values.

Reset
REQ-024 While rst is high at a clock edge, the block SHALL reset:
- FSM to IDLE, pending = 1, bcd_o = 0, busy_o = 0;
- refresh counter = 0, digit index = 0;
- anode_o = 4'b1110, seg_o = the code for 0 (7'b1000000 when SEG_ACTIVE_LOW = 1).
REQ-025 rst asserted mid-conversion SHALL abort the conversion, leaving no partial result in bcd_o.
- After rst is released, a fresh conversion of value_i starts on the first IDLE cycle.

Verification (REFRESH_CNT = 4)
REQ-026 Release reset with value_i = 0:
- busy_o is high for 14 cycles starting 1 cycle after release;
- bcd_o = 16'h0000;
- only digit 0 is lit (anode_o = 1110, seg_o = 1000000); the other slots show 1111.
REQ-027 Set value_i = 1234 from idle:
- bcd_o = 16'h1234 exactly 14 edges after capture;
- the scan shows seg_o 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1) on anode_o 1110, 1101, 1011, 0111.
REQ-028 Set value_i = 8191: bcd_o = 16'h8191 and all four digits are lit.
REQ-029 Set value_i = 100, then 57 three cycles into SHIFT:
- bcd_o first becomes 16'h0100, then 16'h0057 after a second conversion;
- with 57 displayed, anode_o is 1111 in digit slots 2 and 3.
REQ-030 Pulse rst during SHIFT with value_i = 999:
- all outputs take their reset values on the next edge;
- bcd_o = 16'h0999 15 edges after rst deasserts.
REQ-031 Refresh scan: anode_o advances every 4 cycles, wraps from digit 3 to digit 0, and shows exactly one low bit whenever the digit is not blanked.
